// File: rtl/clock_display_if.sv
// rtl/clock_display_if.sv - time input and display output bundle for clock_display
//
// Purpose: groups the time-of-day inputs and the multiplexed display outputs
// of clock_display into one bundle.
// Signals:
//   hour[4:0]    time source -> display, 0..23
//   minute[5:0]  time source -> display, 0..59
//   second[5:0]  time source -> display, 0..59
//   an[5:0]      display -> panel, active-low digit enables
//   seg[6:0]     display -> panel, active-low segments {g,f,e,d,c,b,a}
//   dp           display -> panel, active-low separator
//   frame_start  display -> observer, one-cycle pulse on first frame cycle
// Modports: master = time source / panel side, slave = clock_display.

interface clock_display_if;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output hour, minute, second,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  hour, minute, second,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/clock_display.sv
// rtl/clock_display.sv - six-digit multiplexed HH:MM:SS seven-segment driver
//
// Purpose: scans six active-low seven-segment digits. Each digit gets
// BLANK_CYC all-off cycles (segments already set up) followed by SCAN_DIV
// driven cycles. The time is snapshotted once per frame so a frame never
// mixes two different times.
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      clock_display_if.slave: hour/minute/second in,
//            an/seg/dp/frame_start out (all registered)

module clock_display #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  clock_display_if.slave bus
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [6:0]    SEG_DASH   = 7'b0111111;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  // Low only between reset release and the first edge, which is treated
  // as the edge entering BLANK of digit 0 so the first frame starts there.
  logic          run;
  logic          enter_frame;

  logic [4:0]    snap_hour;
  logic [5:0]    snap_min, snap_sec;
  logic [4:0]    hour_v;
  logic [5:0]    min_v, sec_v;

  logic [5:0]    an_q, an_n;
  logic [6:0]    seg_q, seg_n;
  logic          dp_q, dp_n;
  logic          fs_q;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // Next FSM position.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    enter_frame = 1'b0;
    if (!run) begin
      state_n     = BLANK;
      idx_n       = 3'd0;
      cnt_n       = '0;
      enter_frame = 1'b1;
    end else if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_n = DRIVE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      if (cnt == DRIVE_LAST) begin
        state_n = BLANK;
        cnt_n   = '0;
        if (idx == 3'd5) begin
          idx_n       = 3'd0;
          enter_frame = 1'b1;
        end else begin
          idx_n = idx + 3'd1;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  // Outputs are computed for the next cycle's position so they can be
  // registered; on a frame entry the fresh inputs stand in for the snapshot
  // being captured on that same edge.
  always_comb begin
    hour_v = enter_frame ? bus.hour   : snap_hour;
    min_v  = enter_frame ? bus.minute : snap_min;
    sec_v  = enter_frame ? bus.second : snap_sec;

    seg_n = SEG_DASH;
    case (idx_n)
      3'd0:    seg_n = (sec_v  <= 6'd59) ? seg_code(ones_of(sec_v))           : SEG_DASH;
      3'd1:    seg_n = (sec_v  <= 6'd59) ? seg_code(tens_of(sec_v))           : SEG_DASH;
      3'd2:    seg_n = (min_v  <= 6'd59) ? seg_code(ones_of(min_v))           : SEG_DASH;
      3'd3:    seg_n = (min_v  <= 6'd59) ? seg_code(tens_of(min_v))           : SEG_DASH;
      3'd4:    seg_n = (hour_v <= 5'd23) ? seg_code(ones_of({1'b0, hour_v})) : SEG_DASH;
      3'd5:    seg_n = (hour_v <= 5'd23) ? seg_code(tens_of({1'b0, hour_v})) : SEG_DASH;
      default: seg_n = SEG_DASH;
    endcase

    // Separators light (active-low) on even seconds only.
    dp_n = ((idx_n == 3'd2) || (idx_n == 3'd4)) ? sec_v[0] : 1'b1;
    an_n = (state_n == DRIVE) ? ~(6'b000001 << idx_n) : 6'b111111;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BLANK;
      idx       <= 3'd0;
      cnt       <= '0;
      run       <= 1'b0;
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
      an_q      <= 6'b111111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (enter_frame) begin
        snap_hour <= bus.hour;
        snap_min  <= bus.minute;
        snap_sec  <= bus.second;
      end
      an_q  <= an_n;
      seg_q <= seg_n;
      dp_q  <= dp_n;
      fs_q  <= enter_frame;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_clock_display.sv
// tb/tb_clock_display.sv - scoreboard testbench for clock_display

module tb_clock_display;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mon_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  clock_display_if bus ();

  clock_display #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Frame table: inputs, expected digits {idx5..idx0} (hex A = dash),
  // expected dp per idx (bit i = idx i).
  logic [4:0]  th [7];
  logic [5:0]  tm [7];
  logic [5:0]  ts [7];
  logic [23:0] td [7];
  logic [5:0]  tdp[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push_frame(input int f);
    logic [23:0] digs;
    logic [5:0]  dpm;
    exp_t        e;
    digs = td[f];
    dpm  = tdp[f];
    for (int i = 0; i < 6; i++) begin
      e.an  = ~(6'b000001 << i);
      e.seg = seg_of(digs[i*4 +: 4]);
      e.dp  = dpm[i];
      q.push_back(e);
    end
  endtask

  task automatic set_inputs(input int f);
    bus.hour   = th[f];
    bus.minute = tm[f];
    bus.second = ts[f];
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 100);
    if (!bus.frame_start) begin
      tests++;
      fails++;
      $display("FAIL wait_frame_start: no pulse within %0d cycles", n);
    end
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_scoreboard: %0d entries left after %0d cycles", q.size(), n);
    end
  endtask

  // Monitor: checks blank/drive lengths, frame period, and pops one
  // expected record per driven digit.
  initial begin
    int   cyc = 0;
    int   last_fs = 0;
    bit   have_fs = 0;
    bit   in_drive = 0;
    int   blank_len = 0;
    int   drive_len = 0;
    exp_t cur = '0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mon_en) begin
        cyc = 0; have_fs = 0; in_drive = 0; blank_len = 0; drive_len = 0;
      end else begin
        cyc++;
        if (bus.frame_start) begin
          check("fs_blank_an", bus.an, 6'h3f);
          if (have_fs) check("frame_period", cyc - last_fs, 36);
          have_fs = 1;
          last_fs = cyc;
        end
        if (bus.an == 6'h3f) begin
          if (in_drive) begin
            check("drive_len", drive_len, 4);
            in_drive  = 0;
            blank_len = 0;
          end
          blank_len++;
          if (q.size() > 0) begin
            check("blank_seg", bus.seg, q[0].seg);
            check("blank_dp", bus.dp, q[0].dp);
          end
        end else begin
          if (!in_drive) begin
            check("blank_len", blank_len, 2);
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL scoreboard_underflow: an=%b with nothing expected", bus.an);
              cur = '0;
            end else begin
              cur = q.pop_front();
            end
            in_drive  = 1;
            drive_len = 0;
          end
          drive_len++;
          check("drive_an", bus.an, cur.an);
          check("drive_seg", bus.seg, cur.seg);
          check("drive_dp", bus.dp, cur.dp);
        end
      end
    end
  end

  initial begin
    int n;
    th[0] = 5'd12; tm[0] = 6'd34; ts[0] = 6'd56; td[0] = 24'h123456; tdp[0] = 6'b101011;
    th[1] = 5'd12; tm[1] = 6'd34; ts[1] = 6'd57; td[1] = 24'h123457; tdp[1] = 6'b111111;
    th[2] = 5'd5;  tm[2] = 6'd60; ts[2] = 6'd9;  td[2] = 24'h05AA09; tdp[2] = 6'b111111;
    th[3] = 5'd23; tm[3] = 6'd59; ts[3] = 6'd59; td[3] = 24'h235959; tdp[3] = 6'b111111;
    th[4] = 5'd0;  tm[4] = 6'd0;  ts[4] = 6'd0;  td[4] = 24'h000000; tdp[4] = 6'b101011;
    th[5] = 5'd7;  tm[5] = 6'd8;  ts[5] = 6'd30; td[5] = 24'h070830; tdp[5] = 6'b101011;
    th[6] = 5'd24; tm[6] = 6'd15; ts[6] = 6'd61; td[6] = 24'hAA15AA; tdp[6] = 6'b111111;

    set_inputs(0);
    repeat (3) @(negedge clk);
    check("rst_an", bus.an, 6'h3f);
    check("rst_seg", bus.seg, 7'h7f);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_fs", bus.frame_start, 1'b0);

    push_frame(0);
    mon_en = 1'b1;
    #2 reset_n = 1'b1;

    // Each new time is applied mid-frame; it must appear only next frame.
    for (int f = 1; f < 7; f++) begin
      wait_fs();
      repeat (10) @(negedge clk);
      set_inputs(f);
      push_frame(f);
    end
    wait_fs();
    push_frame(6);
    wait_fs();

    // Reset asserted during DRIVE of digit 3.
    n = 0;
    while (bus.an != 6'b110111 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_drive_idx3", bus.an, 6'b110111);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_an", bus.an, 6'h3f);
    check("async_rst_seg", bus.seg, 7'h7f);
    check("async_rst_dp", bus.dp, 1'b1);
    check("async_rst_fs", bus.frame_start, 1'b0);
    q.delete();
    set_inputs(0);
    push_frame(0);
    repeat (2) @(negedge clk);
    check("held_rst_an", bus.an, 6'h3f);
    check("held_rst_seg", bus.seg, 7'h7f);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("restart_fs", bus.frame_start, 1'b1);
    check("restart_an", bus.an, 6'h3f);
    check("restart_seg", bus.seg, seg_of(4'd6));
    wait_q_empty();
    repeat (5) @(negedge clk);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
